extend_pipe: RTL
================

Name: extend_pipe

Overview:
Pipelined, parametrised immediate extender for the pipelined ARM core. It replaces the combinational Decode-stage extender and adds three things: ARM data-processing rotated immediates with shifter carry-out, halfword-transfer immediates, and an illegal-mode flag. Instructions pass through a ready/valid register pipeline of configurable depth, so Decode can back-pressure when Execute stalls.

Parameters:
DATA_WIDTH, 32, width of ExtImm; legal values are 32 or 64. Bits above 31 are sign- or zero-fill per mode.
PIPE_DEPTH, 2, register stages between input and output; legal values are 1 or 2.
BR_SHIFT, 2, left shift applied to the sign-extended branch offset.

Ports:
clk  in  1  clock; all registers update on the rising edge
reset  in  1  asynchronous, active-low reset
InValid  in  1  Instr/ImmSrc/CarryIn are valid this cycle
InReady  out  1  block can accept an input this cycle
Instr  in  24  instruction bits [23:0]
ImmSrc  in  3  extension mode
CarryIn  in  1  current C flag, used for rotate carry-out
OutValid  out  1  ExtImm/CarryOut/ImmErr are valid
OutReady  in  1  downstream accepts the output
ExtImm  out  DATA_WIDTH  extended immediate
CarryOut  out  1  shifter carry-out
ImmErr  out  1  ImmSrc was illegal

Behaviour:
- Modes (W = DATA_WIDTH):
  - 000: zero-extend Instr[7:0].
  - 001: zero-extend Instr[11:0].
  - 010: sign-extend Instr[23:0] to W, then shift left by BR_SHIFT. Bits shifted out at the top are dropped.
  - 011: rotated immediate. Take the 32-bit value {24'b0, Instr[7:0]} and rotate it right by 2*Instr[11:8]. Zero-extend the result to W.
  - 100: zero-extend {Instr[11:8], Instr[3:0]}.
  - 101: sign-extend Instr[23:0] to W with no shift.
  - 110 and 111: illegal. ExtImm = 0, ImmErr = 1, CarryOut = CarryIn.
- CarryOut:
  - Mode 011 with rotate amount non-zero: bit 31 of the rotated 32-bit value.
  - All other cases: CarryIn passed through.
- ImmErr is 0 for all legal modes.
- Pipeline:
  - Each stage holds a valid bit plus payload.
  - A stage loads when it is empty, or when it is full and the next stage (or the output, for the last stage) is accepting.
  - InReady = stage-1 load condition. It is combinational from OutReady through the stage valid bits; this is intentional, and there is no skid buffer.
  - A transfer occurs when InValid & InReady, or OutValid & OutReady.
- PIPE_DEPTH = 2: stage 1 registers the decoded fields (mode, imm8, rot, imm12, imm24, halfword nibbles, CarryIn). Stage 2 registers the computed ExtImm, CarryOut and ImmErr.
- PIPE_DEPTH = 1: all computation happens before the single register.
- Latency: an accepted input appears at OutValid exactly PIPE_DEPTH cycles later if OutReady is held high.
- Throughput: one per cycle with OutReady high.
- Ordering: strictly FIFO. No drop, no duplication.
- While OutValid = 1 and OutReady = 0, outputs are held stable.
- Capacity is PIPE_DEPTH entries. With the output stalled, InReady deasserts once all stages are full.
- If a stage accepts new data in the same cycle its old data moves on, the new data replaces it. No bubble is inserted.
- Reset (reset = 0):
  - Immediately clears all valid bits. OutValid = 0, ExtImm = 0, CarryOut = 0, ImmErr = 0.
  - While reset is asserted, InReady = 1 and nothing is accepted.
  - Reset mid-stream discards all in-flight entries.
  - The first input can be accepted on the first rising edge after reset deasserts.

Test Plan:
- Mode 011, Instr[11:0] = 0x4FF, CarryIn = 0, PIPE_DEPTH = 2, OutReady = 1 -> after 2 cycles: ExtImm = 0xFF000000, CarryOut = 1, ImmErr = 0.
- Mode 011, Instr[11:0] = 0x080, CarryIn = 1 -> ExtImm = 0x00000080, CarryOut = 1 (pass-through). Repeat with CarryIn = 0 -> CarryOut = 0. Also Instr[11:0] = 0x1FF -> ExtImm = 0xC000003F, CarryOut = 1.
- Mode 010, Instr = 0xFFFFFE -> ExtImm = 0xFFFFFFF8. Mode 010, Instr = 0x000010 -> 0x00000040. With DATA_WIDTH = 64, Instr = 0x800000 -> 0xFFFFFFFFFE000000.
- Backpressure: 5 back-to-back inputs in mode 000 with Instr[7:0] = 0x01..0x05, and OutReady = 0 for cycles 2-5 -> InReady low once 2 entries are held. After OutReady rises, outputs are 0x01..0x05 in order, each exactly once.
- Illegal mode: ImmSrc = 110, CarryIn = 1 -> ExtImm = 0, ImmErr = 1, CarryOut = 1. Next input, mode 100 with Instr[11:0] = 0xA05 -> ExtImm = 0x000000A5, ImmErr = 0.
- Reset mid-stream with 2 entries in flight: assert reset between clock edges -> OutValid drops with no clock edge. After deassert, no stale outputs appear. A new input in mode 001 with Instr[11:0] = 0xFFF -> ExtImm = 0x00000FFF after PIPE_DEPTH cycles.

Source files
------------

// File: rtl/extend_pipe_if.sv
// Handshake and payload bundle for the pipelined immediate extender.
// The master side drives the request fields and OutReady; the extender is the slave.
interface extend_pipe_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  InValid;
    logic                  InReady;
    logic [23:0]           Instr;
    logic [2:0]            ImmSrc;
    logic                  CarryIn;
    logic                  OutValid;
    logic                  OutReady;
    logic [DATA_WIDTH-1:0] ExtImm;
    logic                  CarryOut;
    logic                  ImmErr;

    modport master (
        output InValid, Instr, ImmSrc, CarryIn, OutReady,
        input  InReady, OutValid, ExtImm, CarryOut, ImmErr
    );

    modport slave (
        input  InValid, Instr, ImmSrc, CarryIn, OutReady,
        output InReady, OutValid, ExtImm, CarryOut, ImmErr
    );
endinterface

// File: rtl/extend_pipe.sv
// Pipelined ARM immediate extender: turns Instr/ImmSrc into an extended immediate,
// shifter carry-out and illegal-mode flag behind a PIPE_DEPTH-entry ready/valid pipeline.
module extend_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int PIPE_DEPTH = 2,
    parameter int BR_SHIFT   = 2
) (
    input  logic         clk,
    input  logic         reset,
    extend_pipe_if.slave bus
);

    typedef enum logic [2:0] {
        IMM_B8   = 3'b000,
        IMM_B12  = 3'b001,
        IMM_BR   = 3'b010,
        IMM_ROT  = 3'b011,
        IMM_HW   = 3'b100,
        IMM_SX24 = 3'b101
    } imm_src_e;

    typedef struct packed {
        logic [2:0]  mode;
        logic [7:0]  imm8;
        logic [3:0]  rot;
        logic [11:0] imm12;
        logic [23:0] imm24;
        logic [3:0]  hw_hi;
        logic [3:0]  hw_lo;
        logic        cin;
    } dec_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] ext;
        logic                  cout;
        logic                  err;
    } res_t;

    function automatic dec_t decode(input logic [23:0] instr, input logic [2:0] src,
                                    input logic cin);
        dec_t d;
        d.mode  = src;
        d.imm8  = instr[7:0];
        d.rot   = instr[11:8];
        d.imm12 = instr[11:0];
        d.imm24 = instr;
        d.hw_hi = instr[11:8];
        d.hw_lo = instr[3:0];
        d.cin   = cin;
        return d;
    endfunction

    function automatic res_t compute(input dec_t d);
        res_t                  r;
        logic [31:0]           v;
        logic [4:0]            amt;
        logic [31:0]           rot32;
        logic [DATA_WIDTH-1:0] sx;
        v     = {24'b0, d.imm8};
        amt   = {d.rot, 1'b0};
        // A left shift by 32 yields zero, so amt == 0 degenerates cleanly to v.
        rot32 = (v >> amt) | (v << (6'd32 - {1'b0, amt}));
        sx    = {{(DATA_WIDTH-24){d.imm24[23]}}, d.imm24};
        r      = '0;
        r.cout = d.cin;
        case (d.mode)
            IMM_B8:   r.ext = DATA_WIDTH'(d.imm8);
            IMM_B12:  r.ext = DATA_WIDTH'(d.imm12);
            IMM_BR:   r.ext = sx << BR_SHIFT;
            IMM_ROT: begin
                r.ext = DATA_WIDTH'(rot32);
                if (d.rot != 4'd0) r.cout = rot32[31];
            end
            IMM_HW:   r.ext = DATA_WIDTH'({d.hw_hi, d.hw_lo});
            IMM_SX24: r.ext = sx;
            default:  r.err = 1'b1;
        endcase
        return r;
    endfunction

    logic [PIPE_DEPTH:1] vld_q, vld_d, rdy;
    logic [PIPE_DEPTH:0] vld_chain;
    res_t                res_q, res_d;

    assign vld_chain = {vld_q, bus.InValid};

    // Ready ripples back from OutReady; a full stage still loads if its successor drains.
    always_comb begin
        rdy   = '0;
        vld_d = vld_q;
        rdy[PIPE_DEPTH] = ~vld_q[PIPE_DEPTH] | bus.OutReady;
        for (int k = PIPE_DEPTH - 1; k >= 1; k--)
            rdy[k] = ~vld_q[k] | rdy[k + 1];
        for (int k = 1; k <= PIPE_DEPTH; k++)
            vld_d[k] = rdy[k] ? vld_chain[k - 1] : vld_q[k];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) vld_q <= '0;
        else        vld_q <= vld_d;
    end

    if (PIPE_DEPTH == 2) begin : g_two
        dec_t dec_q, dec_d;

        assign dec_d = decode(bus.Instr, bus.ImmSrc, bus.CarryIn);
        assign res_d = compute(dec_q);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                dec_q <= '0;
                res_q <= '0;
            end else begin
                if (rdy[1] & bus.InValid) dec_q <= dec_d;
                if (rdy[2] & vld_q[1])    res_q <= res_d;
            end
        end
    end else begin : g_one
        assign res_d = compute(decode(bus.Instr, bus.ImmSrc, bus.CarryIn));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset)                    res_q <= '0;
            else if (rdy[1] & bus.InValid) res_q <= res_d;
        end
    end

    assign bus.InReady  = rdy[1];
    assign bus.OutValid = vld_q[PIPE_DEPTH];
    assign bus.ExtImm   = res_q.ext;
    assign bus.CarryOut = res_q.cout;
    assign bus.ImmErr   = res_q.err;

endmodule
